// File: rtl/nt_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nt_monitor_pkg
// Description : Shared FSM encoding and sizing helper for the rare-event monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package nt_monitor_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    // A single channel still needs a one-bit channel index.
    function automatic int chan_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nt_node_pipe.sv
`default_nettype none
// ============================================================================
// Module      : nt_node_pipe
// Description : One channel of the rare-node pipeline, DEPTH register stages.
// Revision    : 1.0 - initial release
// ============================================================================
module nt_node_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    input  logic i_valid,
    output logic o_node,
    output logic o_valid
);

    logic [DEPTH-1:0] r_a;
    logic [DEPTH-1:0] r_b;
    logic [DEPTH-1:0] r_v;
    logic             w_a;
    logic             w_b;

    assign w_a = i_a | i_b;
    assign w_b = ~(i_c & ~i_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_v <= '0;
        end else begin
            r_a[0] <= w_a;
            r_b[0] <= w_b;
            r_v[0] <= i_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_v[k] <= r_v[k-1];
            end
        end
    end

    assign o_node  = r_a[DEPTH-1] & ~r_b[DEPTH-1];
    assign o_valid = r_v[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/nt_rare_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : nt_rare_event_monitor
// Description : Per-channel rare-node pipeline with activation counters and
//               a sticky threshold alarm controlled by an IDLE/ARMED/ALARM FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module nt_rare_event_monitor
    import nt_monitor_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8,
    parameter int THRESH = 16
) (
    input  logic                       I1470_clk,
    input  logic                       I1477_rst,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [WIDTH-1:0]           in_c,
    input  logic [WIDTH-1:0]           in_d,
    input  logic                       in_valid,
    input  logic                       arm,
    input  logic                       clr,
    output logic [WIDTH-1:0]           node,
    output logic                       node_valid,
    output logic                       alarm,
    output logic [chan_w(WIDTH)-1:0]   alarm_chan,
    output logic [1:0]                 state
);

    localparam int               c_CHAN_W  = chan_w(WIDTH);
    localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]             w_node;
    logic [WIDTH-1:0]             w_valid_vec;
    logic                         w_node_valid;
    logic [WIDTH-1:0][CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0][CNT_W-1:0]  w_cnt_plus;
    logic [WIDTH-1:0]             w_inc;
    logic [WIDTH-1:0]             w_hit;
    logic                         w_any_hit;
    logic [c_CHAN_W-1:0]          w_hit_chan;
    logic [c_CHAN_W-1:0]          r_alarm_chan;
    state_e                       r_state;
    state_e                       w_state_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            nt_node_pipe #(
                .DEPTH (DEPTH)
            ) u_pipe (
                .clk     (I1470_clk),
                .rst     (I1477_rst),
                .i_a     (in_a[gi]),
                .i_b     (in_b[gi]),
                .i_c     (in_c[gi]),
                .i_d     (in_d[gi]),
                .i_valid (in_valid),
                .o_node  (w_node[gi]),
                .o_valid (w_valid_vec[gi])
            );
        end
    endgenerate

    // Every lane carries an identical copy of the valid bit.
    assign w_node_valid = &w_valid_vec;
    assign node         = w_node;
    assign node_valid   = w_node_valid;

    // Saturating increment and threshold detection; lowest channel wins ties.
    always_comb begin
        w_inc      = '0;
        w_hit      = '0;
        w_cnt_plus = r_cnt;
        w_hit_chan = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_plus[i] = r_cnt[i] + c_CNT_ONE;
            w_inc[i]      = (r_state == ST_ARMED) && w_node_valid && w_node[i]
                            && (r_cnt[i] != c_CNT_MAX);
            w_hit[i]      = w_inc[i] && (w_cnt_plus[i] == c_THRESH);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_chan = c_CHAN_W'(i);
            end
        end
    end

    assign w_any_hit = |w_hit;

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (arm) w_state_next = ST_ARMED;
                ST_ARMED: if (w_any_hit) w_state_next = ST_ALARM;
                ST_ALARM: w_state_next = ST_ALARM;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state      = r_state;
        alarm      = (r_state == ST_ALARM);
        alarm_chan = r_alarm_chan;
    end

    // Counters are zero outside ARMED/ALARM and frozen once the alarm is up.
    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            r_cnt <= '0;
        end else if (clr || ((r_state != ST_ARMED) && (r_state != ST_ALARM))) begin
            r_cnt <= '0;
        end else if (r_state == ST_ARMED) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_inc[i]) begin
                    r_cnt[i] <= w_cnt_plus[i];
                end
            end
        end
    end

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            r_alarm_chan <= '0;
        end else if (clr) begin
            r_alarm_chan <= '0;
        end else if ((r_state == ST_ARMED) && w_any_hit) begin
            r_alarm_chan <= w_hit_chan;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nt_rare_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nt_rare_event_monitor
// Description : Directed self-checking bench for nt_rare_event_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nt_rare_event_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_a, in_b, in_c, in_d;
    logic       in_valid, arm, clr;

    logic [3:0] node1, node2;
    logic       node_valid1, node_valid2;
    logic       alarm1, alarm2;
    logic [1:0] chan1, chan2;
    logic [1:0] state1, state2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nt_rare_event_monitor #(
        .WIDTH(4), .DEPTH(2), .CNT_W(8), .THRESH(16)
    ) dut (
        .I1470_clk(clk), .I1477_rst(rst),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .in_valid(in_valid), .arm(arm), .clr(clr),
        .node(node1), .node_valid(node_valid1), .alarm(alarm1),
        .alarm_chan(chan1), .state(state1)
    );

    nt_rare_event_monitor #(
        .WIDTH(4), .DEPTH(2), .CNT_W(4), .THRESH(15)
    ) dut2 (
        .I1470_clk(clk), .I1477_rst(rst),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .in_valid(in_valid), .arm(arm), .clr(clr),
        .node(node2), .node_valid(node_valid2), .alarm(alarm2),
        .alarm_chan(chan2), .state(state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Channels set in pat produce node=1: a=1, b=0, c=1, d=0.
    task automatic drive(input logic [3:0] pat, input logic v);
        in_a = pat; in_b = 4'h0; in_c = pat; in_d = 4'h0; in_valid = v;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; clr = 1'b0;
        drive(4'h0, 1'b0);
        step(2);
        chk("rst_node",   node1,       4'h0);
        chk("rst_nvalid", node_valid1, 1'b0);
        chk("rst_alarm",  alarm1,      1'b0);
        chk("rst_chan",   chan1,       2'd0);
        chk("rst_state",  state1,      2'd0);
        chk("rst_state2", state2,      2'd0);

        // Two-stage latency on channel 0
        rst = 1'b0;
        drive(4'h1, 1'b1);
        step(1);
        drive(4'h0, 1'b0);
        chk("lat_e1_nvalid", node_valid1, 1'b0);
        chk("lat_e1_node",   node1,       4'h0);
        step(1);
        chk("lat_e2_nvalid", node_valid1, 1'b1);
        chk("lat_e2_node",   node1,       4'h1);
        chk("lat_idle",      state1,      2'd0);
        step(1);
        chk("lat_e3_nvalid", node_valid1, 1'b0);

        // Channel 2 reaches 16 counts; arm stays high throughout
        drive(4'h4, 1'b1);
        step(2);
        arm = 1'b1;
        step(1);
        chk("c2_armed", state1, 2'd1);
        step(15);
        chk("c2_15_alarm", alarm1, 1'b0);
        chk("c2_15_state", state1, 2'd1);
        step(1);
        chk("c2_16_alarm", alarm1, 1'b1);
        chk("c2_16_chan",  chan1,  2'd2);
        chk("c2_16_state", state1, 2'd2);
        step(3);
        chk("c2_hold_alarm", alarm1, 1'b1);
        chk("c2_hold_chan",  chan1,  2'd2);
        chk("c2_hold_state", state1, 2'd2);

        // clr beats arm in ALARM; counters restart from zero
        clr = 1'b1; arm = 1'b1;
        step(1);
        chk("clr_state", state1, 2'd0);
        chk("clr_alarm", alarm1, 1'b0);
        chk("clr_chan",  chan1,  2'd0);
        clr = 1'b0; arm = 1'b0;
        step(1);
        chk("clr_stay_idle", state1, 2'd0);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        chk("rearm_state", state1, 2'd1);
        step(15);
        chk("rearm_15_alarm", alarm1, 1'b0);
        step(1);
        chk("rearm_16_alarm", alarm1, 1'b1);
        chk("rearm_16_chan",  chan1,  2'd2);

        // Channels 1 and 3 tie; lowest index wins
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        drive(4'hA, 1'b1);
        step(2);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(15);
        chk("tie_15_alarm", alarm1, 1'b0);
        step(1);
        chk("tie_16_alarm", alarm1, 1'b1);
        chk("tie_16_chan",  chan1,  2'd1);

        // Asynchronous reset mid-count
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        drive(4'h1, 1'b1);
        step(2);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(7);
        chk("pre_rst_state",  state1,      2'd1);
        chk("pre_rst_nvalid", node_valid1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_state",  state1,      2'd0);
        chk("async_nvalid", node_valid1, 1'b0);
        chk("async_node",   node1,       4'h0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("post_rst_e1_nvalid", node_valid1, 1'b0);
        step(1);
        chk("post_rst_e2_nvalid", node_valid1, 1'b1);
        chk("post_rst_e2_node",   node1,       4'h1);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(15);
        chk("post_rst_15_alarm", alarm1, 1'b0);
        step(1);
        chk("post_rst_16_alarm", alarm1, 1'b1);
        chk("post_rst_16_chan",  chan1,  2'd0);

        // Narrow-counter instance: invalid samples never count
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        drive(4'hF, 1'b0);
        step(2);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(20);
        chk("inv_alarm2",  alarm2,      1'b0);
        chk("inv_state2",  state2,      2'd1);
        chk("inv_nvalid2", node_valid2, 1'b0);
        in_valid = 1'b1;
        step(2);
        step(14);
        chk("w4_14_alarm2", alarm2, 1'b0);
        step(1);
        chk("w4_15_alarm2", alarm2, 1'b1);
        chk("w4_15_chan2",  chan2,  2'd0);
        chk("w4_15_alarm1", alarm1, 1'b0);
        step(1);
        chk("w8_16_alarm1", alarm1, 1'b1);
        chk("w4_hold_state2", state2, 2'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/nt_rare_event_monitor.md
NT_RARE_EVENT_MONITOR -- requirements
Module: nt_rare_event_monitor

Interface
REQ-001 Parameter WIDTH, default 4: number of independent channels.
REQ-002 Parameter DEPTH, default 2, legal range 1..8: number of register stages from input sampling to rare-node output.
REQ-003 Parameter CNT_W, default 8: width of each per-channel activation counter.
REQ-004 Parameter THRESH, default 16, legal range 1..2^CNT_W-1: activation count that raises the alarm.
REQ-005 Port I1470_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port I1477_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Ports in_a, in_b, in_c, in_d, input, WIDTH bits each: per-channel source signals.
REQ-008 Port in_valid, input, 1 bit: qualifies in_a..in_d in the current cycle.
REQ-009 Port arm, input, 1 bit: level-sampled request to start monitoring.
REQ-010 Port clr, input, 1 bit: synchronous clear of counters and FSM.
REQ-011 Port node, output, WIDTH bits: registered rare-node values.
REQ-012 Port node_valid, output, 1 bit: qualifies node.
REQ-013 Port alarm, output, 1 bit: sticky alarm flag.
REQ-014 Port alarm_chan, output, $clog2(WIDTH) bits (minimum 1): channel that raised the alarm.
REQ-015 Port state, output, 2 bits: current FSM state encoding.

Function
REQ-016 Stage 1 registers, per channel i: A1[i] = in_a[i] | in_b[i]; B1[i] = ~(in_c[i] & ~in_d[i]); V1 = in_valid.
REQ-017 Stages 2..DEPTH copy the previous stage unconditionally every cycle; no stall, no bubble removal.
REQ-018 node[i] = A_DEPTH[i] & ~B_DEPTH[i]; node_valid = V_DEPTH; node therefore reflects inputs sampled exactly DEPTH cycles earlier.
REQ-019 FSM states: IDLE=0, ARMED=1, ALARM=2; encoding 3 is illegal and SHALL return to IDLE on the next edge.
REQ-020 IDLE -> ARMED when arm=1 and clr=0; counters held at 0 in IDLE.
REQ-021 In ARMED, counter[i] increments by 1 on each edge where node_valid=1 and node[i]=1; saturates at 2^CNT_W-1, never wraps.
REQ-022 ARMED -> ALARM on the edge where any counter[i] becomes equal to THRESH; alarm=1 and alarm_chan=i registered on that same edge.
REQ-023 Several channels reaching THRESH on the same edge: alarm_chan = lowest index.
REQ-024 In ALARM, counters, alarm_chan and alarm are frozen; arm is ignored.
REQ-025 clr=1 in any state: next state IDLE, all counters 0, alarm=0, alarm_chan=0; clr has priority over arm and over threshold detection in the same cycle.
REQ-026 arm held high in ARMED has no effect; arm deasserting does not leave ARMED.
REQ-027 The pipeline (REQ-016..018) runs in every state, including IDLE and ALARM, and is unaffected by clr.

Reset
REQ-028 While I1477_rst=1, all pipeline stages, node, node_valid, counters, alarm, alarm_chan are 0 and state is IDLE, independent of clock.
REQ-029 Reset asserted mid-operation clears all state immediately; first node_valid after release occurs no earlier than DEPTH edges after the first in_valid=1 sample.

Structure
REQ-030 FSM state enum and encoding constants SHALL live in shared package nt_monitor_pkg.
REQ-031 One sub-module nt_node_pipe SHALL implement REQ-016..018 for a single channel (parameter DEPTH), instantiated WIDTH times; counters and FSM live in the top.

Verification
REQ-032 DEPTH=2: in_a=1,in_b=0,in_c=1,in_d=0,in_valid=1 on ch0 at cycle 0 -> node[0]=1, node_valid=1 after edge 2, not after edge 1.
REQ-033 THRESH=16, armed, ch2 node=1 for 16 valid cycles -> alarm=1, alarm_chan=2, state=ALARM on the 16th counting edge; counters frozen afterward.
REQ-034 ch1 and ch3 both reach THRESH on the same edge -> alarm_chan=1.
REQ-035 In ALARM assert clr and arm together -> next state IDLE, alarm=0, counters 0; ARMED only after a later arm without clr.
REQ-036 Assert I1477_rst asynchronously between edges in ARMED with count=7 -> outputs 0 and state IDLE before next edge; node_valid stays 0 for DEPTH edges after release.
REQ-037 CNT_W=4, THRESH=15, node_valid=0 with node pattern 1 -> counters stay 0, no alarm.
